fetch_unit: RTL and testbench

//  Instruction fetch stage upstream of the core datapath. Owns the PC and issues

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
// Defaults here are the parameter defaults of fetch_unit.
package fetch_unit_pkg;

  localparam int          WORD_SIZE  = 32;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with synchronous clear; head is read straight from the entry registers.
// Push becomes visible at the head one cycle later; a push when full is accepted only with a pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order memory requests, buffers {instr, pc} for decode.
// Push-to-head latency 1 cycle; requests stall while FIFO entries plus in-flight words fill the FIFO.
module fetch_unit #(
  parameter int                   WORD_SIZE  = fetch_unit_pkg::WORD_SIZE,
  parameter int                   FIFO_DEPTH = fetch_unit_pkg::FIFO_DEPTH,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = fetch_unit_pkg::RESET_PC
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_MemReq,
  output logic [WORD_SIZE-1:0] o_MemAddr,
  input  logic                 i_MemGnt,
  input  logic                 i_MemRvalid,
  input  logic [WORD_SIZE-1:0] i_MemRdata,
  output logic                 o_InstrValid,
  output logic [WORD_SIZE-1:0] o_Instruction,
  output logic [WORD_SIZE-1:0] o_InstrPc,
  input  logic                 i_InstrReady,
  input  logic                 i_Redirect,
  input  logic [WORD_SIZE-1:0] i_RedirectPc
);

  import fetch_unit_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e           state_q, state_d;
  logic [WORD_SIZE-1:0]   fetch_pc_q, fetch_pc_d;
  logic [WORD_SIZE-1:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0]          outstanding_q, outstanding_d;
  logic [CW-1:0]          discard_q, discard_d;
  logic [CW-1:0]          fifo_count;
  logic [CW:0]            inflight;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   mem_req;
  logic                   grant;
  logic                   push;
  logic                   pop;
  logic [WORD_SIZE-1:0]   redirect_pc;
  logic [2*WORD_SIZE-1:0] head_dat;
  logic                   unused_pc_bits;

  // Redirect targets are word aligned; the low address bits carry no information.
  assign redirect_pc    = {i_RedirectPc[WORD_SIZE-1:2], 2'b00};
  assign unused_pc_bits = ^i_RedirectPc[1:0];
  assign inflight       = {1'b0, fifo_count} + {1'b0, outstanding_q};

  always_comb begin
    mem_req       = 1'b0;
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;

    // Reserving a slot per in-flight word means a response always has room.
    if (state_q == FETCH_RUN && !fifo_full && inflight < (CW+1)'(FIFO_DEPTH)) begin
      mem_req = 1'b1;
    end
    grant = mem_req && i_MemGnt;
    push  = i_MemRvalid && (discard_q == '0) && !i_Redirect;
    pop   = !fifo_empty && i_InstrReady && !i_Redirect;

    outstanding_d = outstanding_q + CW'(grant) - CW'(i_MemRvalid);
    if (i_MemRvalid && discard_q != '0) begin
      discard_d = discard_q - 1'b1;
    end
    if (grant) begin
      fetch_pc_d = fetch_pc_q + WORD_SIZE'(4);
    end
    if (push) begin
      resp_pc_d = resp_pc_q + WORD_SIZE'(4);
    end

    // Everything still in flight after this cycle, including a same-cycle grant, is stale.
    if (i_Redirect) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      discard_d  = outstanding_d;
    end

    case (state_q)
      FETCH_IDLE:  state_d = FETCH_RUN;
      FETCH_RUN:   if (i_Redirect && outstanding_d != '0) state_d = FETCH_FLUSH;
      FETCH_FLUSH: if (discard_d == '0) state_d = FETCH_RUN;
      default:     state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= FETCH_IDLE;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .WIDTH (2*WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .clr_i      (i_Redirect),
    .push_i     (push),
    .push_dat_i ({i_MemRdata, resp_pc_q}),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign o_MemReq      = mem_req;
  assign o_MemAddr     = fetch_pc_q;
  assign o_InstrValid  = !fifo_empty;
  assign o_Instruction = head_dat[2*WORD_SIZE-1:WORD_SIZE];
  assign o_InstrPc     = head_dat[WORD_SIZE-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-programmable memory model plus an in-order PC scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        i_clk;
  logic        i_rst;
  logic        o_MemReq;
  logic [31:0] o_MemAddr;
  logic        i_MemGnt;
  logic        i_MemRvalid;
  logic [31:0] i_MemRdata;
  logic        o_InstrValid;
  logic [31:0] o_Instruction;
  logic [31:0] o_InstrPc;
  logic        i_InstrReady;
  logic        i_Redirect;
  logic [31:0] i_RedirectPc;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          lat         = 1;
  int          gcount      = 0;
  int          hs_cnt      = 0;
  logic        gnt_en      = 1'b0;
  logic [31:0] exp_q  [$];
  logic [31:0] pend_a [$];
  int          pend_t [$];

  fetch_unit dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_MemReq      (o_MemReq),
    .o_MemAddr     (o_MemAddr),
    .i_MemGnt      (i_MemGnt),
    .i_MemRvalid   (i_MemRvalid),
    .i_MemRdata    (i_MemRdata),
    .o_InstrValid  (o_InstrValid),
    .o_Instruction (o_Instruction),
    .o_InstrPc     (o_InstrPc),
    .i_InstrReady  (i_InstrReady),
    .i_Redirect    (i_Redirect),
    .i_RedirectPc  (i_RedirectPc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  assign i_MemGnt = o_MemReq & gnt_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Memory: grants recorded at negedge, responses driven in order lat cycles later.
  always @(negedge i_clk) begin
    if (i_rst) begin
      pend_a.delete();
      pend_t.delete();
    end else if (o_MemReq && i_MemGnt) begin
      pend_a.push_back(o_MemAddr);
      pend_t.push_back(cyc + lat);
      gcount++;
    end
  end

  always @(posedge i_clk) begin
    cyc = cyc + 1;
    #1;
    if (pend_a.size() != 0 && pend_t[0] <= cyc) begin
      i_MemRvalid = 1'b1;
      i_MemRdata  = mem_word(pend_a.pop_front());
      pend_t.delete(0);
    end else begin
      i_MemRvalid = 1'b0;
      i_MemRdata  = '0;
    end
  end

  // Scoreboard monitor: every accepted instruction must be the next expected PC.
  always @(negedge i_clk) begin
    if (!i_rst && !i_Redirect && o_InstrValid && i_InstrReady) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got pc %h, want no instruction", o_InstrPc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", o_InstrPc, e);
        chk("pop_instr", o_Instruction, mem_word(e));
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  // Called with i_rst already high or about to be; holds it for one edge.
  task automatic do_reset();
    i_rst      = 1'b1;
    i_Redirect = 1'b0;
    step();
    chk("rst_req",   32'(o_MemReq), 32'd0);
    chk("rst_addr",  o_MemAddr, RST_PC);
    chk("rst_vld",   32'(o_InstrValid), 32'd0);
    chk("rst_instr", o_Instruction, 32'd0);
    chk("rst_pc",    o_InstrPc, 32'd0);
    i_rst = 1'b0;
    chk("idle_req",  32'(o_MemReq), 32'd0);
    step();
    chk("first_req",  32'(o_MemReq), 32'd1);
    chk("first_addr", o_MemAddr, RST_PC);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d words still expected after %0d cycles, want 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
    i_InstrReady = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    int n;
    int h0;
    i_rst        = 1'b1;
    i_Redirect   = 1'b0;
    i_RedirectPc = '0;
    i_InstrReady = 1'b0;
    i_MemRvalid  = 1'b0;
    i_MemRdata   = '0;
    step();

    // 1: streaming at one instruction per cycle
    gnt_en = 1'b1; lat = 1; i_InstrReady = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    do_reset();
    repeat (4) step();
    h0 = hs_cnt;
    repeat (8) step();
    chk("t1_rate", 32'(hs_cnt - h0), 32'd8);
    drain("t1_drain", 40);

    // 2: consumer stalled, exactly FIFO_DEPTH fetches then stall
    gcount = 0;
    do_reset();
    repeat (10) step();
    chk("t2_grants",     32'(gcount), 32'd4);
    chk("t2_req_off",    32'(o_MemReq), 32'd0);
    chk("t2_head_vld",   32'(o_InstrValid), 32'd1);
    chk("t2_head_pc",    o_InstrPc, 32'h0);
    chk("t2_head_instr", o_Instruction, mem_word(32'h0));
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    i_InstrReady = 1'b1;
    drain("t2_drain", 40);

    // 3: redirect with two slow requests in flight
    lat = 3; gnt_en = 1'b1; i_InstrReady = 1'b1; gcount = 0;
    do_reset();
    n = 0;
    while (gcount < 2 && n < 10) begin
      step();
      n++;
    end
    chk("t3_two_grants", 32'(gcount), 32'd2);
    gnt_en = 1'b0; i_Redirect = 1'b1; i_RedirectPc = 32'h100;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    step();
    i_Redirect = 1'b0; gnt_en = 1'b1;
    chk("t3_flush_req",  32'(o_MemReq), 32'd0);
    chk("t3_flush_addr", o_MemAddr, 32'h100);
    drain("t3_drain", 40);

    // 4: redirect coinciding with a pop and a response, unaligned target
    lat = 1; gnt_en = 1'b1; i_InstrReady = 1'b1;
    for (int i = 0; i < 12; i++) exp_q.push_back(32'(i * 4));
    do_reset();
    repeat (8) step();
    chk("t4_resp_and_pop", {30'd0, i_MemRvalid, o_InstrValid}, 32'd3);
    i_Redirect = 1'b1; i_RedirectPc = 32'h203;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + 32'(i * 4));
    step();
    i_Redirect = 1'b0;
    chk("t4_vld_cleared", 32'(o_InstrValid), 32'd0);
    drain("t4_drain", 40);

    // 5: PC wrap at the top of the address space
    i_Redirect = 1'b1; i_RedirectPc = 32'hFFFF_FFFC; i_InstrReady = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    step();
    i_Redirect = 1'b0;
    drain("t5_drain", 40);

    // 6a: reset with a full FIFO
    lat = 1; gnt_en = 1'b1; i_InstrReady = 1'b0;
    repeat (8) step();
    chk("t6_full_vld", 32'(o_InstrValid), 32'd1);
    chk("t6_full_req", 32'(o_MemReq), 32'd0);
    do_reset();

    // 6b: reset while flushing stale slow responses
    lat = 3;
    step();
    i_Redirect = 1'b1; i_RedirectPc = 32'h300;
    step();
    i_Redirect = 1'b0;
    chk("t6_flush_req", 32'(o_MemReq), 32'd0);
    for (int i = 0; i < 3; i++) exp_q.push_back(RST_PC + 32'(i * 4));
    i_InstrReady = 1'b1;
    do_reset();
    drain("t6_drain", 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
